updown_time_datapath: RTL and testbench

Parametrised successor to the stopwatch datapath: a 100 Hz-tick cascaded msec/sec/min/hour counter with an internal run FSM. Counts up (stopwatch) or down (countdown timer with expiry). Adds single-cycle carry/borrow across all fields, per-field edit while stopped, and lap capture. Sits between the button controller and fnd_controller.

---
 rtl/updown_time_datapath.sv | 192 +++++++++++++++++++
 tb/tb_updown_time_datapath.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_time_datapath.sv
// Cascaded msec/sec/min/hour counter with run FSM: counts up as a stopwatch or down as a
// countdown timer with expiry, supports per-field editing while stopped and lap capture.
module updown_time_datapath #(
  parameter int FCOUNT   = 1_000_000,
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_stop,
  input  logic       clear,
  input  logic       mode,
  input  logic [1:0] edit_sel,
  input  logic       edit_inc,
  input  logic       edit_dec,
  input  logic       lap,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [6:0] lap_msec,
  output logic [5:0] lap_sec,
  output logic [5:0] lap_min,
  output logic [4:0] lap_hour,
  output logic       lap_valid,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(FCOUNT - 1);
  localparam logic [6:0]    HOUR_LAST = 7'(HOUR_MOD - 1);

  typedef enum logic [1:0] {S_STOP, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic [6:0]    msec_q, msec_d, lap_msec_q, lap_msec_d;
  logic [5:0]    sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [5:0]    min_q, min_d, lap_min_q, lap_min_d;
  logic [4:0]    hour_q, hour_d, lap_hour_q, lap_hour_d;
  logic          lap_valid_q, lap_valid_d;
  logic          done_q, done_d;
  logic          tick, time_nz, last_hundredth;

  function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] last);
    return (v == last) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] dec_wrap(input logic [6:0] v, input logic [6:0] last);
    return (v == 7'd0) ? last : v - 7'd1;
  endfunction

  assign tick           = (state_q == S_RUN) && (presc_q == PRE_LAST);
  assign time_nz        = |{hour_q, min_q, sec_q, msec_q};
  assign last_hundredth = ({hour_q, min_q, sec_q} == '0) && (msec_q == 7'd1);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    dir_d       = dir_q;
    msec_d      = msec_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    lap_msec_d  = lap_msec_q;
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_hour_d  = lap_hour_q;
    lap_valid_d = lap_valid_q;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = S_STOP;
      presc_d     = '0;
      msec_d      = '0;
      sec_d       = '0;
      min_d       = '0;
      hour_d      = '0;
      lap_msec_d  = '0;
      lap_sec_d   = '0;
      lap_min_d   = '0;
      lap_hour_d  = '0;
      lap_valid_d = 1'b0;
    end else begin
      // Lap samples the registered time, so a coincident tick is not yet visible.
      if (lap) begin
        lap_msec_d  = msec_q;
        lap_sec_d   = sec_q;
        lap_min_d   = min_q;
        lap_hour_d  = hour_q;
        lap_valid_d = 1'b1;
      end
      case (state_q)
        S_STOP: begin
          if (run_stop && (!mode || time_nz)) begin
            state_d = S_RUN;
            dir_d   = mode;
          end else if (edit_inc ^ edit_dec) begin
            case (edit_sel)
              2'd0: msec_d = edit_inc ? inc_wrap(msec_q, 7'd99) : dec_wrap(msec_q, 7'd99);
              2'd1: sec_d  = 6'(edit_inc ? inc_wrap({1'b0, sec_q}, 7'd59)
                                         : dec_wrap({1'b0, sec_q}, 7'd59));
              2'd2: min_d  = 6'(edit_inc ? inc_wrap({1'b0, min_q}, 7'd59)
                                         : dec_wrap({1'b0, min_q}, 7'd59));
              default: hour_d = 5'(edit_inc ? inc_wrap({2'b0, hour_q}, HOUR_LAST)
                                            : dec_wrap({2'b0, hour_q}, HOUR_LAST));
            endcase
          end
        end
        S_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          // Whole carry/borrow chain resolves combinationally within the tick cycle.
          if (tick && !dir_q) begin
            msec_d = inc_wrap(msec_q, 7'd99);
            if (msec_q == 7'd99) begin
              sec_d = 6'(inc_wrap({1'b0, sec_q}, 7'd59));
              if (sec_q == 6'd59) begin
                min_d = 6'(inc_wrap({1'b0, min_q}, 7'd59));
                if (min_q == 6'd59) hour_d = 5'(inc_wrap({2'b0, hour_q}, HOUR_LAST));
              end
            end
          end else if (tick && dir_q) begin
            msec_d = dec_wrap(msec_q, 7'd99);
            if (msec_q == 7'd0) begin
              sec_d = 6'(dec_wrap({1'b0, sec_q}, 7'd59));
              if (sec_q == 6'd0) begin
                min_d = 6'(dec_wrap({1'b0, min_q}, 7'd59));
                if (min_q == 6'd0) hour_d = 5'(dec_wrap({2'b0, hour_q}, HOUR_LAST));
              end
            end
          end
          if (!run_stop) begin
            state_d = S_STOP;
          end else if (tick && dir_q && last_hundredth) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: if (!run_stop) state_d = S_STOP;
        default: state_d = S_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_STOP;
      presc_q     <= '0;
      dir_q       <= 1'b0;
      msec_q      <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      lap_msec_q  <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hour_q  <= '0;
      lap_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      dir_q       <= dir_d;
      msec_q      <= msec_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      lap_msec_q  <= lap_msec_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_hour_q  <= lap_hour_d;
      lap_valid_q <= lap_valid_d;
      done_q      <= done_d;
    end
  end

  assign msec      = msec_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign lap_msec  = lap_msec_q;
  assign lap_sec   = lap_sec_q;
  assign lap_min   = lap_min_q;
  assign lap_hour  = lap_hour_q;
  assign lap_valid = lap_valid_q;
  assign running   = (state_q == S_RUN);
  assign expired   = (state_q == S_DONE);
  assign done      = done_q;

endmodule

// File: tb/tb_updown_time_datapath.sv
// Directed bench for updown_time_datapath with a 4-cycle prescaler.
module tb_updown_time_datapath;

  logic       clk = 1'b0;
  logic       reset_n, run_stop, clear, mode, edit_inc, edit_dec, lap;
  logic [1:0] edit_sel;
  logic [6:0] msec, lap_msec;
  logic [5:0] sec, min, lap_sec, lap_min;
  logic [4:0] hour, lap_hour;
  logic       lap_valid, running, expired, done;
  int         tests_run = 0;
  int         tests_failed = 0;

  updown_time_datapath #(.FCOUNT(4), .HOUR_MOD(24)) dut (
    .clk(clk), .reset_n(reset_n), .run_stop(run_stop), .clear(clear), .mode(mode),
    .edit_sel(edit_sel), .edit_inc(edit_inc), .edit_dec(edit_dec), .lap(lap),
    .msec(msec), .sec(sec), .min(min), .hour(hour),
    .lap_msec(lap_msec), .lap_sec(lap_sec), .lap_min(lap_min), .lap_hour(lap_hour),
    .lap_valid(lap_valid), .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pulse_edit(input logic [1:0] sel, input logic inc, input logic dec);
    edit_sel = sel;
    edit_inc = inc;
    edit_dec = dec;
    step(1);
    edit_inc = 1'b0;
    edit_dec = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({hour, min, sec, msec, lap_hour, lap_min, lap_sec, lap_msec} !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_time: got %h/%h required 0", {hour, min, sec, msec},
               {lap_hour, lap_min, lap_sec, lap_msec});
    end
    tests_run++;
    if ({lap_valid, running, expired, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 0000", {lap_valid, running, expired, done});
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_up_count();
    do_clear();
    mode = 1'b0;
    run_stop = 1'b1;
    step(1);
    tests_run++;
    if ({running, msec} !== {1'b1, 7'd0}) begin
      tests_failed++;
      $display("FAIL up_enter_run: got running=%b msec=%0d required 1/0", running, msec);
    end
    mode = 1'b1;
    step(3);
    tests_run++;
    if (msec !== 7'd0) begin
      tests_failed++;
      $display("FAIL up_before_tick: got %0d required 0", msec);
    end
    step(1);
    tests_run++;
    if (msec !== 7'd1) begin
      tests_failed++;
      $display("FAIL up_first_tick: got %0d required 1", msec);
    end
    step(395);
    tests_run++;
    if ({sec, msec} !== {6'd0, 7'd99}) begin
      tests_failed++;
      $display("FAIL up_99: got sec=%0d msec=%0d required 0/99", sec, msec);
    end
    step(1);
    tests_run++;
    if ({sec, msec} !== {6'd1, 7'd0}) begin
      tests_failed++;
      $display("FAIL up_carry_sec: got sec=%0d msec=%0d required 1/0", sec, msec);
    end
    run_stop = 1'b0;
    step(1);
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++;
      $display("FAIL up_stop: got running=%b required 0", running);
    end
    mode = 1'b0;
  endtask

  task automatic test_edit_wrap();
    do_clear();
    pulse_edit(2'd3, 1'b0, 1'b1);
    pulse_edit(2'd2, 1'b0, 1'b1);
    pulse_edit(2'd1, 1'b0, 1'b1);
    pulse_edit(2'd0, 1'b0, 1'b1);
    tests_run++;
    if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
      tests_failed++;
      $display("FAIL edit_dec_wrap: got %0d:%0d:%0d.%0d required 23:59:59.99", hour, min, sec, msec);
    end
    pulse_edit(2'd1, 1'b1, 1'b0);
    tests_run++;
    if ({min, sec} !== {6'd59, 6'd0}) begin
      tests_failed++;
      $display("FAIL edit_inc_nocarry: got min=%0d sec=%0d required 59/0", min, sec);
    end
    pulse_edit(2'd1, 1'b0, 1'b1);
    run_stop = 1'b1;
    step(4);
    tests_run++;
    if ({running, hour, min, sec, msec} !== {1'b1, 5'd23, 6'd59, 6'd59, 7'd99}) begin
      tests_failed++;
      $display("FAIL wrap_pre_tick: got run=%b %0d:%0d:%0d.%0d required 1 23:59:59.99",
               running, hour, min, sec, msec);
    end
    step(1);
    tests_run++;
    if ({hour, min, sec, msec, done, running} !== {24'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_all_zero: got %0d:%0d:%0d.%0d done=%b run=%b required 0 0 1",
               hour, min, sec, msec, done, running);
    end
    run_stop = 1'b0;
    step(1);
  endtask

  task automatic test_countdown();
    do_clear();
    mode = 1'b1;
    pulse_edit(2'd1, 1'b1, 1'b0);
    tests_run++;
    if ({sec, msec} !== {6'd1, 7'd0}) begin
      tests_failed++;
      $display("FAIL down_edit: got sec=%0d msec=%0d required 1/0", sec, msec);
    end
    run_stop = 1'b1;
    step(5);
    tests_run++;
    if ({running, sec, msec} !== {1'b1, 6'd0, 7'd99}) begin
      tests_failed++;
      $display("FAIL down_borrow: got run=%b sec=%0d msec=%0d required 1/0/99", running, sec, msec);
    end
    step(395);
    tests_run++;
    if ({running, done, sec, msec} !== {1'b1, 1'b0, 6'd0, 7'd1}) begin
      tests_failed++;
      $display("FAIL down_last: got run=%b done=%b sec=%0d msec=%0d required 1/0/0/1",
               running, done, sec, msec);
    end
    step(1);
    tests_run++;
    if ({done, expired, running, msec} !== {1'b1, 1'b1, 1'b0, 7'd0}) begin
      tests_failed++;
      $display("FAIL down_expire: got done=%b exp=%b run=%b msec=%0d required 1/1/0/0",
               done, expired, running, msec);
    end
    step(1);
    tests_run++;
    if ({done, expired} !== 2'b01) begin
      tests_failed++;
      $display("FAIL down_done_pulse: got done=%b exp=%b required 0/1", done, expired);
    end
    step(3);
    tests_run++;
    if ({hour, min, sec, msec, expired} !== {24'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL down_hold: got %h exp=%b required 0/1", {hour, min, sec, msec}, expired);
    end
    run_stop = 1'b0;
    step(1);
    tests_run++;
    if ({expired, running} !== 2'b00) begin
      tests_failed++;
      $display("FAIL down_to_stop: got exp=%b run=%b required 0/0", expired, running);
    end
  endtask

  task automatic test_zero_down();
    do_clear();
    mode = 1'b1;
    run_stop = 1'b1;
    step(3);
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_down_stays: got running=%b required 0", running);
    end
    pulse_edit(2'd1, 1'b1, 1'b0);
    tests_run++;
    if ({sec, running} !== {6'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL zero_down_edit: got sec=%0d run=%b required 1/0", sec, running);
    end
    step(1);
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_down_start: got running=%b required 1", running);
    end
    run_stop = 1'b0;
    step(1);
    mode = 1'b0;
  endtask

  task automatic test_lap();
    do_clear();
    run_stop = 1'b1;
    step(152);
    tests_run++;
    if ({lap_valid, msec} !== {1'b0, 7'd37}) begin
      tests_failed++;
      $display("FAIL lap_pre: got valid=%b msec=%0d required 0/37", lap_valid, msec);
    end
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    tests_run++;
    if ({lap_valid, lap_msec, msec, lap_hour, lap_min, lap_sec} !== {1'b1, 7'd37, 7'd38, 17'd0}) begin
      tests_failed++;
      $display("FAIL lap_capture: got valid=%b lap_msec=%0d msec=%0d required 1/37/38",
               lap_valid, lap_msec, msec);
    end
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    tests_run++;
    if ({hour, min, sec, msec, lap_msec, lap_valid, running} !== {24'd0, 7'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL lap_clear: got msec=%0d lap_msec=%0d valid=%b run=%b required 0/0/0/0",
               msec, lap_msec, lap_valid, running);
    end
    step(1);
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_restart_up: got running=%b required 1", running);
    end
    run_stop = 1'b0;
    step(1);
    pulse_edit(2'd0, 1'b1, 1'b0);
    pulse_edit(2'd0, 1'b1, 1'b0);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    tests_run++;
    if ({lap_valid, lap_msec} !== {1'b1, 7'd2}) begin
      tests_failed++;
      $display("FAIL lap_overwrite: got valid=%b lap_msec=%0d required 1/2", lap_valid, lap_msec);
    end
    lap = 1'b1;
    clear = 1'b1;
    step(1);
    lap = 1'b0;
    clear = 1'b0;
    tests_run++;
    if ({lap_valid, lap_msec, msec} !== {1'b0, 7'd0, 7'd0}) begin
      tests_failed++;
      $display("FAIL clear_beats_lap: got valid=%b lap_msec=%0d msec=%0d required 0/0/0",
               lap_valid, lap_msec, msec);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    run_stop = 1'b1;
    step(9);
    tests_run++;
    if (msec !== 7'd2) begin
      tests_failed++;
      $display("FAIL pre_reset_count: got %0d required 2", msec);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({msec, running} !== {7'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got msec=%0d run=%b required 0/0", msec, running);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_run: got running=%b required 1", running);
    end
    pulse_edit(2'd1, 1'b1, 1'b0);
    tests_run++;
    if (sec !== 6'd0) begin
      tests_failed++;
      $display("FAIL edit_in_run: got sec=%0d required 0", sec);
    end
    run_stop = 1'b0;
    step(1);
    pulse_edit(2'd1, 1'b1, 1'b1);
    tests_run++;
    if ({running, sec} !== {1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL edit_both: got run=%b sec=%0d required 0/0", running, sec);
    end
    pulse_edit(2'd1, 1'b1, 1'b0);
    tests_run++;
    if (sec !== 6'd1) begin
      tests_failed++;
      $display("FAIL edit_in_stop: got sec=%0d required 1", sec);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    run_stop = 1'b0;
    clear    = 1'b0;
    mode     = 1'b0;
    edit_sel = 2'd0;
    edit_inc = 1'b0;
    edit_dec = 1'b0;
    lap      = 1'b0;
    step(1);
    test_reset();
    test_up_count();
    test_edit_wrap();
    test_countdown();
    test_zero_down();
    test_lap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
